// File: rtl/object_bus_scanner.sv
// Polls object cells on a shared wired-AND id bus one slot at a time, builds a present-mask
// and queues every (slot, id) answer into a small valid/ready output FIFO.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; sel released
// S_SETTLE | sel driven to the current slot, bus allowed to settle
// S_SAMPLE | bus evaluated; push answer or stall while the queue is full
// S_DONE   | one-cycle done pulse, then back to idle
module object_bus_scanner #(
  parameter int NUM_SLOTS  = 8,
  parameter int ID_W       = 4,
  parameter int SETTLE     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start,
  input  logic [ID_W-1:0]                                  bus_data,
  output logic [NUM_SLOTS-1:0]                             sel,
  output logic                                             busy,
  output logic                                             done,
  output logic [NUM_SLOTS-1:0]                             present_mask,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [ID_W-1:0]                                  out_id,
  output logic [(NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1)-1:0] out_slot
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [SLOT_W-1:0]    LAST_SLOT   = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0]     SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [PTR_W-1:0]     PTR_LAST    = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [FCNT_W-1:0]    FULL_CNT    = FCNT_W'(FIFO_DEPTH);
  localparam logic [NUM_SLOTS-1:0] SEL_FIRST   = NUM_SLOTS'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t                state_q;
  logic [NUM_SLOTS-1:0]  sel_q;
  logic                  busy_q;
  logic                  done_q;
  logic [NUM_SLOTS-1:0]  mask_q;
  logic [SLOT_W-1:0]     slot_q;
  logic [CNT_W-1:0]      scnt_q;

  logic [ID_W-1:0]       mem_id_q   [FIFO_DEPTH];
  logic [SLOT_W-1:0]     mem_slot_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [FCNT_W-1:0]     fcnt_q;

  logic                  fifo_full;
  logic                  pop;
  logic                  push_req;
  logic                  stall;
  logic                  push;

  // An empty slot never needs queue space, so only a pending push can stall the scan.
  always_comb begin
    fifo_full = (fcnt_q == FULL_CNT);
    pop       = (fcnt_q != '0) && out_ready;
    push_req  = (state_q == S_SAMPLE) && !(&bus_data);
    stall     = push_req && fifo_full && !pop;
    push      = push_req && !stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mask_q  <= '0;
      slot_q  <= '0;
      scnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mask_q  <= '0;
            slot_q  <= '0;
            scnt_q  <= SETTLE_LOAD;
            sel_q   <= SEL_FIRST;
            busy_q  <= 1'b1;
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (scnt_q == '0) state_q <= S_SAMPLE;
          else              scnt_q  <= scnt_q - 1'b1;
        end
        S_SAMPLE: begin
          if (push) mask_q[slot_q] <= 1'b1;
          if (!stall) begin
            if (slot_q == LAST_SLOT) begin
              sel_q   <= '0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              slot_q  <= slot_q + 1'b1;
              scnt_q  <= SETTLE_LOAD;
              sel_q   <= sel_q << 1;
              state_q <= S_SETTLE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_id_q[i]   <= '0;
        mem_slot_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_id_q[wr_ptr_q]   <= bus_data;
        mem_slot_q[wr_ptr_q] <= slot_q;
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      fcnt_q <= fcnt_q + 1'b1;
      else if (pop && !push) fcnt_q <= fcnt_q - 1'b1;
    end
  end

  assign sel          = sel_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign present_mask = mask_q;
  assign out_valid    = (fcnt_q != '0);
  assign out_id       = mem_id_q[rd_ptr_q];
  assign out_slot     = mem_slot_q[rd_ptr_q];

endmodule

// File: tb/tb_object_bus_scanner.sv
// Directed bench for object_bus_scanner: 4 slots, SETTLE=2, 2-entry queue, wired-AND bus model.
module tb_object_bus_scanner;
  localparam int NS = 4;
  localparam int IW = 4;
  localparam int ST = 2;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          out_ready;
  logic [IW-1:0] bus_data;
  logic [NS-1:0] sel;
  logic          busy;
  logic          done;
  logic [NS-1:0] present_mask;
  logic          out_valid;
  logic [IW-1:0] out_id;
  logic [1:0]    out_slot;

  logic [IW-1:0] cell_id [NS];
  logic [NS-1:0] fitted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]    got_slot [$];
  logic [IW-1:0] got_id   [$];

  object_bus_scanner #(.NUM_SLOTS(NS), .ID_W(IW), .SETTLE(ST), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .bus_data(bus_data),
    .sel(sel), .busy(busy), .done(done), .present_mask(present_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_slot(out_slot)
  );

  always #5 clk = ~clk;

  // Unselected cells release the pulled-up bus; selected fitted cells pull bits low.
  always_comb begin
    bus_data = '1;
    for (int i = 0; i < NS; i++)
      if (sel[i] && fitted[i]) bus_data = bus_data & cell_id[i];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; fitted = '0;
    for (int i = 0; i < NS; i++) cell_id[i] = '1;
    step(); step();
    n_checks++;
    if (sel !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got sel=%b busy=%b done=%b, expected 0000 0 0", sel, busy, done);
    end
    n_checks++;
    if (present_mask !== 4'b0000 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mask_valid: got mask=%b valid=%b, expected 0000 0", present_mask, out_valid);
    end
    n_checks++;
    if (out_id !== 4'b0000 || out_slot !== 2'd0) begin
      n_fail++; $display("FAIL reset_head: got id=%b slot=%0d, expected 0000 0", out_id, out_slot);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_scan();
    logic [NS-1:0] exp_sel;
    fitted = 4'b1010; cell_id[1] = 4'b0101; cell_id[3] = 4'b1101; out_ready = 1'b1;
    got_slot.delete(); got_id.delete();
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      exp_sel = (c <= 12) ? (4'b0001 << ((c - 1) / 3)) : 4'b0000;
      n_checks++;
      if (sel !== exp_sel || done !== (c == 13) || busy !== (c <= 13)) begin
        n_fail++;
        $display("FAIL basic_timing cycle %0d: got sel=%b done=%b busy=%b, expected %b %b %b",
                 c, sel, done, busy, exp_sel, (c == 13), (c <= 13));
      end
      if (out_valid && out_ready) begin got_slot.push_back(out_slot); got_id.push_back(out_id); end
      step();
    end
    n_checks++;
    if (got_slot.size() != 2) begin
      n_fail++; $display("FAIL basic_count: got %0d entries, expected 2", got_slot.size());
    end else begin
      n_checks++;
      if (got_slot[0] !== 2'd1 || got_id[0] !== 4'b0101 || got_slot[1] !== 2'd3 || got_id[1] !== 4'b1101) begin
        n_fail++;
        $display("FAIL basic_entries: got (%0d,%b) (%0d,%b), expected (1,0101) (3,1101)",
                 got_slot[0], got_id[0], got_slot[1], got_id[1]);
      end
    end
    n_checks++;
    if (present_mask !== 4'b1010) begin
      n_fail++; $display("FAIL basic_mask: got %b expected 1010", present_mask);
    end
  endtask

  task automatic test_empty_scan();
    fitted = '0; out_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      n_checks++;
      if (out_valid !== 1'b0 || done !== (c == 13)) begin
        n_fail++;
        $display("FAIL empty_cycle %0d: got valid=%b done=%b, expected 0 %b", c, out_valid, done, (c == 13));
      end
      step();
    end
    n_checks++;
    if (present_mask !== 4'b0000) begin
      n_fail++; $display("FAIL empty_mask: got %b expected 0000", present_mask);
    end
  endtask

  task automatic test_stall_drain();
    logic done_seen;
    fitted = 4'b1111;
    cell_id[0] = 4'b0001; cell_id[1] = 4'b0010; cell_id[2] = 4'b0011; cell_id[3] = 4'b0100;
    out_ready = 1'b0;
    got_slot.delete(); got_id.delete();
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    n_checks++;
    if (sel !== 4'b0100 || busy !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_state: got sel=%b busy=%b valid=%b, expected 0100 1 1", sel, busy, out_valid);
    end
    n_checks++;
    if (out_slot !== 2'd0 || out_id !== 4'b0001) begin
      n_fail++; $display("FAIL stall_head: got (%0d,%b) expected (0,0001)", out_slot, out_id);
    end
    step();
    n_checks++;
    if (sel !== 4'b0100 || out_slot !== 2'd0) begin
      n_fail++; $display("FAIL stall_hold: got sel=%b slot=%0d, expected 0100 0", sel, out_slot);
    end
    out_ready = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin got_slot.push_back(out_slot); got_id.push_back(out_id); end
      if (done) done_seen = 1'b1;
      if (done_seen && !out_valid) break;
      step();
    end
    n_checks++;
    if (!done_seen) begin
      n_fail++; $display("FAIL stall_done: got no done within budget, expected done pulse");
    end
    n_checks++;
    if (got_slot.size() != 4) begin
      n_fail++; $display("FAIL stall_count: got %0d entries, expected 4", got_slot.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_slot[i] !== 2'(i) || got_id[i] !== 4'(i + 1)) begin
          n_fail++; $display("FAIL stall_entry %0d: got (%0d,%b) expected (%0d,%b)", i, got_slot[i], got_id[i], i, 4'(i + 1));
        end
      end
    end
    n_checks++;
    if (present_mask !== 4'b1111) begin
      n_fail++; $display("FAIL stall_mask: got %b expected 1111", present_mask);
    end
  endtask

  task automatic test_start_held();
    int done_cnt;
    fitted = '0; out_ready = 1'b1;
    done_cnt = 0;
    start = 1'b1; step();
    for (int c = 1; c <= 13; c++) begin
      if (done) done_cnt++;
      step();
    end
    n_checks++;
    if (done_cnt != 1 || busy !== 1'b0 || sel !== 4'b0000) begin
      n_fail++; $display("FAIL held_one_scan: got dones=%0d busy=%b sel=%b, expected 1 0 0000", done_cnt, busy, sel);
    end
    step();
    n_checks++;
    if (busy !== 1'b1 || sel !== 4'b0001) begin
      n_fail++; $display("FAIL held_rescan: got busy=%b sel=%b, expected 1 0001", busy, sel);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    rst = 1'b1; step(); rst = 1'b0; step();
    fitted = 4'b0010; cell_id[1] = 4'b0110; out_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 7; k++) step();
    n_checks++;
    if (sel !== 4'b0100 || out_valid !== 1'b1 || out_slot !== 2'd1 || present_mask !== 4'b0010) begin
      n_fail++; $display("FAIL midrst_pre: got sel=%b valid=%b slot=%0d mask=%b, expected 0100 1 1 0010",
                         sel, out_valid, out_slot, present_mask);
    end
    rst = 1'b1; step();
    n_checks++;
    if (sel !== 4'b0000 || busy !== 1'b0 || out_valid !== 1'b0 || present_mask !== 4'b0000 || out_id !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_post: got sel=%b busy=%b valid=%b mask=%b id=%b, expected 0000 0 0 0000 0000",
                         sel, busy, out_valid, present_mask, out_id);
    end
    rst = 1'b0; step();
  endtask

  task automatic test_full_push_pop();
    logic done_seen;
    logic [IW-1:0] exp_id [3];
    fitted = 4'b1111;
    cell_id[0] = 4'b1010; cell_id[1] = 4'b1011; cell_id[2] = 4'b1100; cell_id[3] = 4'b0111;
    exp_id[0] = 4'b1011; exp_id[1] = 4'b1100; exp_id[2] = 4'b0111;
    out_ready = 1'b0;
    got_slot.delete(); got_id.delete();
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 8; k++) step();
    n_checks++;
    if (sel !== 4'b0100 || out_slot !== 2'd0 || out_id !== 4'b1010) begin
      n_fail++; $display("FAIL fullpp_pre: got sel=%b head=(%0d,%b), expected 0100 (0,1010)", sel, out_slot, out_id);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (sel !== 4'b1000 || out_valid !== 1'b1 || out_slot !== 2'd1 || out_id !== 4'b1011) begin
      n_fail++; $display("FAIL fullpp_nostall: got sel=%b valid=%b head=(%0d,%b), expected 1000 1 (1,1011)",
                         sel, out_valid, out_slot, out_id);
    end
    n_checks++;
    if (present_mask !== 4'b0111) begin
      n_fail++; $display("FAIL fullpp_mask: got %b expected 0111", present_mask);
    end
    out_ready = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin got_slot.push_back(out_slot); got_id.push_back(out_id); end
      if (done) done_seen = 1'b1;
      if (done_seen && !out_valid) break;
      step();
    end
    n_checks++;
    if (!done_seen || got_slot.size() != 3) begin
      n_fail++; $display("FAIL fullpp_drain: got done=%b entries=%0d, expected 1 3", done_seen, got_slot.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got_slot[i] !== 2'(i + 1) || got_id[i] !== exp_id[i]) begin
          n_fail++; $display("FAIL fullpp_entry %0d: got (%0d,%b) expected (%0d,%b)", i, got_slot[i], got_id[i], i + 1, exp_id[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_empty_scan();
    test_stall_drain();
    test_start_held();
    test_reset_mid_scan();
    test_full_push_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end
endmodule
